// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives the s1/s0 selects of a 4:1 mux, scans the enabled
// channels in ascending order and captures y_in on each channel's last dwell cycle.
//
// Parameter DWELL (1..255): cycles each enabled channel stays selected.
// Optional macro MUX_SCAN_CONTINUOUS_EN: after DONE, re-latch mask and rescan forever.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   start    scan request, sampled only in IDLE
//   mask     channel enables, latched on accepted start
//   y_in     mux output
//   s0, s1   registered mux select (channel = {s1,s0})
//   busy     scan in progress (through the DONE cycle)
//   done     one-cycle completion pulse
//   valid    samples holds a completed scan
//   samples  captured bit per channel
module mux_scan_sequencer #(
   parameter int unsigned DWELL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] mask,
   input  logic       y_in,
   output logic       s0,
   output logic       s1,
   output logic       busy,
   output logic       done,
   output logic       valid,
   output logic [3:0] samples
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       ch_q, ch_d;
   logic [3:0]       mask_q, mask_d;
   logic [3:0]       samples_d;
   logic             busy_d, done_d, valid_d;
   logic [2:0]       first_port;
   logic [2:0]       first_higher;

   // Returns {found, index} of the lowest set bit.
   function automatic logic [2:0] first_set(input logic [3:0] m);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   // Lowest enabled channel on the port, and next enabled channel above ch_q.
   always_comb begin
      first_port   = first_set(mask);
      first_higher = first_set(mask_q & 4'(4'b1110 << ch_q));
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ch_q    <= 2'b00;
         mask_q  <= 4'b0000;
         samples <= 4'b0000;
         busy    <= 1'b0;
         done    <= 1'b0;
         valid   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         mask_q  <= mask_d;
         samples <= samples_d;
         busy    <= busy_d;
         done    <= done_d;
         valid   <= valid_d;
      end
   end

   assign s1 = ch_q[1];
   assign s0 = ch_q[0];

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ch_d      = ch_q;
      mask_d    = mask_q;
      samples_d = samples;
      busy_d    = busy;
      done_d    = 1'b0;
      valid_d   = valid;

      unique case (state_q)
         IDLE: begin
            ch_d = 2'b00;
            if (start) begin
               mask_d    = mask;
               valid_d   = 1'b0;
               samples_d = 4'b0000;
               busy_d    = 1'b1;
               cnt_d     = '0;
               if (first_port[2]) begin
                  state_d = SCAN;
                  ch_d    = first_port[1:0];
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end

         SCAN: begin
            if (cnt_q == CNT_W'(DWELL - 1)) begin
               samples_d[ch_q] = y_in;
               cnt_d           = '0;
               if (first_higher[2]) begin
                  ch_d = first_higher[1:0];
               end else begin
                  state_d = DONE;
                  ch_d    = 2'b00;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            valid_d = 1'b1;
            ch_d    = 2'b00;
`ifdef MUX_SCAN_CONTINUOUS_EN
            // Next pass starts immediately with a freshly latched mask.
            mask_d    = mask;
            samples_d = 4'b0000;
            cnt_d     = '0;
            if (first_port[2]) begin
               state_d = SCAN;
               ch_d    = first_port[1:0];
            end else begin
               done_d = 1'b1;
            end
`else
            state_d = IDLE;
            busy_d  = 1'b0;
`endif
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed self-checking bench for mux_scan_sequencer (DWELL=4 and DWELL=1 instances).
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, start1;
   logic [3:0] mask, mask1;
   logic [3:0] ivec;
   logic       y_in, y1;
   logic       s0, s1, busy, done, valid;
   logic       s0_1, s1_1, busy1, done1, valid1;
   logic [3:0] samples, samples1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Mux model: y follows the input selected by each DUT's select lines.
   assign y_in = ivec[{s1, s0}];
   assign y1   = ivec[{s1_1, s0_1}];

   mux_scan_sequencer #(.DWELL(4)) dut (
      .clk(clk), .rst(rst), .start(start), .mask(mask), .y_in(y_in),
      .s0(s0), .s1(s1), .busy(busy), .done(done), .valid(valid), .samples(samples)
   );

   mux_scan_sequencer #(.DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .mask(mask1), .y_in(y1),
      .s0(s0_1), .s1(s1_1), .busy(busy1), .done(done1), .valid(valid1), .samples(samples1)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One single-shot scan; cycle 1 is the cycle after the start edge.
   task automatic run_scan(input string tag, input logic [3:0] m, input logic [3:0] iv,
                           input int exp_len, input logic [3:0] exp_s, input bit disturb);
      int ens[4];
      int n;
      int exp_ch;
      n = 0;
      ens = '{0, 0, 0, 0};
      for (int b = 0; b < 4; b++) begin
         if (m[b]) begin
            ens[n] = b;
            n++;
         end
      end
      ivec  = iv;
      mask  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= exp_len; c++) begin
         if (disturb && c == 3) mask = 4'b0001;
         if (disturb && c == 5) start = 1'b1;
         if (disturb && c == 6) start = 1'b0;
         exp_ch = (c == exp_len) ? 0 : ens[(c - 1) / 4];
         chk({tag, "_sel"}, 8'({s1, s0}), 8'(exp_ch));
         chk({tag, "_done"}, 8'(done), 8'(c == exp_len));
         chk({tag, "_busy"}, 8'(busy), 8'd1);
         tick();
      end
      chk({tag, "_valid"}, 8'(valid), 8'd1);
      chk({tag, "_samples"}, 8'(samples), 8'(exp_s));
      chk({tag, "_idle_busy"}, 8'(busy), 8'd0);
      chk({tag, "_idle_done"}, 8'(done), 8'd0);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      start1 = 1'b0;
      mask   = 4'b0000;
      mask1  = 4'b0000;
      ivec   = 4'b0000;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_sel", 8'({s1, s0}), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(done), 8'd0);
      chk("rst_valid", 8'(valid), 8'd0);
      chk("rst_samples", 8'(samples), 8'd0);

`ifdef MUX_SCAN_CONTINUOUS_EN
      // mask=0011, DWELL=4: done every 2*4+1 = 9 cycles.
      ivec  = 4'b0011;
      mask  = 4'b0011;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         chk("cont_done", 8'(done), 8'(c % 9 == 0));
         chk("cont_busy", 8'(busy), 8'd1);
         if (c > 9) chk("cont_valid", 8'(valid), 8'd1);
         tick();
      end
`else
      // Full scan: i0..i3 = 1,0,1,1 -> samples 1101, done at cycle 17.
      run_scan("full", 4'b1111, 4'b1101, 17, 4'b1101, 1'b0);
      // Sparse: only ch0/ch2 selected; disabled inputs high yet samples bits stay 0.
      run_scan("sparse", 4'b0101, 4'b1111, 9, 4'b0101, 1'b0);
      // Empty mask: DONE right after start.
      run_scan("empty", 4'b0000, 4'b1111, 1, 4'b0000, 1'b0);
      // Mid-scan start pulse and mask change have no effect.
      run_scan("disturb", 4'b1111, 4'b0110, 17, 4'b0110, 1'b1);

      // start held high: re-accepted on the first IDLE cycle after DONE.
      mask  = 4'b0000;
      start = 1'b1;
      tick();
      chk("hold_done1", 8'(done), 8'd1);
      tick();
      chk("hold_idle_busy", 8'(busy), 8'd0);
      chk("hold_idle_valid", 8'(valid), 8'd1);
      tick();
      chk("hold_done2", 8'(done), 8'd1);
      chk("hold_valid_clr", 8'(valid), 8'd0);
      start = 1'b0;
      tick();
      tick();

      // Reset mid-scan at cycle 6 (ch1 selected by then).
      mask  = 4'b1111;
      ivec  = 4'b1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 6; c++) tick();
      chk("mid_sel_before", 8'({s1, s0}), 8'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_sel", 8'({s1, s0}), 8'd0);
      chk("mid_rst_busy", 8'(busy), 8'd0);
      chk("mid_rst_done", 8'(done), 8'd0);
      chk("mid_rst_valid", 8'(valid), 8'd0);
      chk("mid_rst_samples", 8'(samples), 8'd0);

      // DWELL=1 instance: select changes every cycle, done at cycle 5.
      ivec   = 4'b1010;
      mask1  = 4'b1111;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         chk("d1_sel", 8'({s1_1, s0_1}), 8'((c == 5) ? 0 : c - 1));
         chk("d1_done", 8'(done1), 8'(c == 5));
         tick();
      end
      chk("d1_valid", 8'(valid1), 8'd1);
      chk("d1_samples", 8'(samples1), 8'b1010);
      chk("d1_busy", 8'(busy1), 8'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
